// File: rtl/exposure_ctrl_param.sv
// Erase/expose/read sequencer for a row-readout image sensor.
// Define EXP_CTRL_CONTINUOUS_EN for back-to-back frames while Init stays high.
module exposure_ctrl_param #(
  parameter int ROWS         = 2,
  parameter int EXP_W        = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_INIT     = 10,
  parameter int ERASE_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  output logic             Erase,
  output logic             Expose,
  output logic             ADC,
  output logic [ROWS-1:0]  NRE,
  output logic [EXP_W-1:0] Exp_time,
  output logic             Busy,
  output logic             Frame_done
);

  localparam int EC_W  = $clog2(ERASE_CYCLES + 1);
  localparam int CNT_W = (EC_W > EXP_W) ? EC_W : EXP_W;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [EXP_W-1:0] MAX_V      = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] MIN_V      = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] INIT_V     = EXP_W'(EXP_INIT);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ERASE, EXPOSE, READ} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row;
  logic             phase;
  logic             init_q;
  logic             inc_q;
  logic             dec_q;
  logic             init_rise;
  logic             inc_rise;
  logic             dec_rise;
  logic             restart;

  assign init_rise = Init & ~init_q;
  assign inc_rise  = Exp_increase & ~inc_q;
  assign dec_rise  = Exp_decrease & ~dec_q;

`ifdef EXP_CTRL_CONTINUOUS_EN
  assign restart = Init;
`else
  assign restart = 1'b0;
`endif

  function automatic logic [ROWS-1:0] row_mask(input logic [ROW_W-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  // Outputs are registered from the next state, so each strobe
  // lines up exactly with the state it belongs to.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      init_q     <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      Exp_time   <= INIT_V;
      Erase      <= 1'b0;
      Expose     <= 1'b0;
      ADC        <= 1'b0;
      NRE        <= '1;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      init_q     <= Init;
      inc_q      <= Exp_increase;
      dec_q      <= Exp_decrease;
      Erase      <= 1'b0;
      Expose     <= 1'b0;
      ADC        <= 1'b0;
      NRE        <= '1;
      Frame_done <= 1'b0;

      if (inc_rise && !dec_rise) begin
        if (Exp_time < MAX_V) Exp_time <= Exp_time + 1'b1;
      end else if (dec_rise && !inc_rise) begin
        if (Exp_time > MIN_V) Exp_time <= Exp_time - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (init_rise) begin
            state <= ERASE;
            cnt   <= ERASE_LAST;
            Erase <= 1'b1;
            Busy  <= 1'b1;
          end
        end
        ERASE: begin
          if (cnt == '0) begin
            state  <= EXPOSE;
            cnt    <= CNT_W'(Exp_time) - 1'b1;
            Expose <= 1'b1;
          end else begin
            cnt   <= cnt - 1'b1;
            Erase <= 1'b1;
          end
        end
        EXPOSE: begin
          if (cnt == '0) begin
            state <= READ;
            row   <= '0;
            phase <= 1'b0;
            NRE   <= row_mask('0);
          end else begin
            cnt    <= cnt - 1'b1;
            Expose <= 1'b1;
          end
        end
        READ: begin
          if (!phase) begin
            phase <= 1'b1;
            ADC   <= 1'b1;
            NRE   <= row_mask(row);
          end else if (row != ROW_LAST) begin
            row   <= row + 1'b1;
            phase <= 1'b0;
            NRE   <= row_mask(row + 1'b1);
          end else begin
            Frame_done <= 1'b1;
            if (restart) begin
              state <= ERASE;
              cnt   <= ERASE_LAST;
              Erase <= 1'b1;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exposure_ctrl_param.sv
// Bench for exposure_ctrl_param: frame scoreboard plus exposure adjust table.
// Build with EXP_CTRL_CONTINUOUS_EN to run the back-to-back frame case.
`timescale 1ns/1ps
module tb_exposure_ctrl_param;

`ifdef EXP_CTRL_CONTINUOUS_EN
  localparam int ROWS = 4;
`else
  localparam int ROWS = 2;
`endif
  localparam int ERASE_N = 4;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Init = 1'b0;
  logic            Exp_increase = 1'b0;
  logic            Exp_decrease = 1'b0;
  logic            Erase;
  logic            Expose;
  logic            ADC;
  logic [ROWS-1:0] NRE;
  logic [4:0]      Exp_time;
  logic            Busy;
  logic            Frame_done;

  typedef struct {
    int erase;
    int expose;
    int adc;
    int nre_low;
  } frame_t;

  typedef struct {
    int n_inc;
    int n_dec;
    int n_both;
    int exp_t;
  } adj_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int n_tests = 0;
  int n_fail = 0;
  int c_erase = 0;
  int c_expose = 0;
  int c_adc = 0;
  int c_nre = 0;
  int n_done = 0;

  exposure_ctrl_param #(
    .ROWS(ROWS),
    .EXP_W(5),
    .EXP_MIN(2),
    .EXP_MAX(30),
    .EXP_INIT(10),
    .ERASE_CYCLES(ERASE_N)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Init(Init),
    .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease),
    .Erase(Erase),
    .Expose(Expose),
    .ADC(ADC),
    .NRE(NRE),
    .Exp_time(Exp_time),
    .Busy(Busy),
    .Frame_done(Frame_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Frame monitor: strobe counts since the previous Frame_done are
  // compared against the scoreboard entry for the frame just ended.
  always @(negedge Clk) begin
    if (!Reset) begin
      c_erase = 0;
      c_expose = 0;
      c_adc = 0;
      c_nre = 0;
    end else begin
      if (Frame_done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          mon_f = exp_q.pop_front();
          chk("frame_erase_cycles", c_erase, mon_f.erase);
          chk("frame_expose_cycles", c_expose, mon_f.expose);
          chk("frame_adc_cycles", c_adc, mon_f.adc);
          chk("frame_nre_low_cycles", c_nre, mon_f.nre_low);
        end
        c_erase = 0;
        c_expose = 0;
        c_adc = 0;
        c_nre = 0;
      end
      c_erase += int'(Erase);
      c_expose += int'(Expose);
      c_adc += int'(ADC);
      c_nre += ROWS - $countones(NRE);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input bit inc, input bit dec);
    Exp_increase = inc;
    Exp_decrease = dec;
    tick();
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    tick();
  endtask

  task automatic push_frame(input int expo);
    frame_t f;
    f.erase = ERASE_N;
    f.expose = expo;
    f.adc = ROWS;
    f.nre_low = 2 * ROWS;
    exp_q.push_back(f);
  endtask

  task automatic start_frame();
    Init = 1'b1;
    tick();
    Init = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output int lows);
    n = 0;
    lows = 0;
    do begin
      if (!Busy) lows++;
      tick();
      n++;
    end while (!Frame_done && n < limit);
    if (!Frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  initial begin
    adj_t tbl[6];
    int n;
    int lows;
    int d0;

    tbl[0] = '{25, 0, 0, 30};
    tbl[1] = '{0, 40, 0, 2};
    tbl[2] = '{8, 0, 0, 10};
    tbl[3] = '{0, 0, 3, 10};
    tbl[4] = '{1, 0, 0, 11};
    tbl[5] = '{0, 1, 0, 10};

    tick();
    tick();
    chk("reset_erase", int'(Erase), 0);
    chk("reset_expose", int'(Expose), 0);
    chk("reset_adc", int'(ADC), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_frame_done", int'(Frame_done), 0);
    chk("reset_nre", int'(NRE), (1 << ROWS) - 1);
    chk("reset_exp_time", int'(Exp_time), 10);
    Reset = 1'b1;
    tick();

    push_frame(10);
    start_frame();
    chk("erase_first_cycle", int'(Erase), 1);
    chk("busy_in_frame", int'(Busy), 1);
    wait_done(200, n, lows);
    chk("frame_length", n, ERASE_N + 10 + 2 * ROWS);
    tick();
    chk("busy_after_frame", int'(Busy), 0);
    chk("frame_done_width", int'(Frame_done), 0);
    chk("frames_seen", n_done, 1);

    for (int i = 0; i < 6; i++) begin
      repeat (tbl[i].n_inc) pulse(1'b1, 1'b0);
      repeat (tbl[i].n_dec) pulse(1'b0, 1'b1);
      repeat (tbl[i].n_both) pulse(1'b1, 1'b1);
      chk($sformatf("exp_adjust_%0d", i), int'(Exp_time), tbl[i].exp_t);
    end

    push_frame(10);
    start_frame();
    repeat (6) tick();
    chk("in_expose", int'(Expose), 1);
    pulse(1'b1, 1'b0);
    wait_done(200, n, lows);
    chk("running_exposure_len", n + 8, ERASE_N + 10 + 2 * ROWS);
    chk("exp_time_after_inc", int'(Exp_time), 11);
    tick();
    push_frame(11);
    start_frame();
    wait_done(200, n, lows);
    chk("next_frame_len", n, ERASE_N + 11 + 2 * ROWS);
    tick();
    pulse(1'b0, 1'b1);
    chk("exp_time_restored", int'(Exp_time), 10);

`ifndef EXP_CTRL_CONTINUOUS_EN
    d0 = n_done;
    push_frame(10);
    Init = 1'b1;
    tick();
    repeat (40) tick();
    Init = 1'b0;
    tick();
    chk("held_init_frames", n_done - d0, 1);
    chk("held_init_busy", int'(Busy), 0);
`endif

    start_frame();
    repeat (ERASE_N + 10 + 2) tick();
    chk("pre_reset_nre", int'(NRE), ((1 << ROWS) - 1) & ~2);
    d0 = n_done;
    Reset = 1'b0;
    #1;
    chk("abort_erase", int'(Erase), 0);
    chk("abort_expose", int'(Expose), 0);
    chk("abort_adc", int'(ADC), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_frame_done", int'(Frame_done), 0);
    chk("abort_nre", int'(NRE), (1 << ROWS) - 1);
    chk("abort_exp_time", int'(Exp_time), 10);
    tick();
    Reset = 1'b1;
    repeat (40) tick();
    chk("abort_no_frame_done", n_done - d0, 0);
    chk("abort_stays_idle", int'(Busy), 0);

`ifdef EXP_CTRL_CONTINUOUS_EN
    d0 = n_done;
    push_frame(10);
    Init = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      wait_done(200, n, lows);
      chk($sformatf("cont_period_%0d", f), n, ERASE_N + 10 + 2 * ROWS);
      chk($sformatf("cont_busy_low_%0d", f), lows, 0);
      chk($sformatf("cont_busy_done_%0d", f), int'(Busy), 1);
      push_frame(10);
    end
    Init = 1'b0;
    wait_done(200, n, lows);
    chk("cont_last_period", n, ERASE_N + 10 + 2 * ROWS);
    chk("cont_last_busy_low", lows, 0);
    tick();
    chk("cont_idle_after", int'(Busy), 0);
    chk("cont_frames", n_done - d0, 4);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
